acc_sequencer: RTL and testbench

Sequences the custom accelerator ops (opcodes 6'b111111 and 6'b111110) for the 5-stage MIPS pipeline. It sits beside the main controller in decode. It detects an accelerator op in D, stalls F/D, drives a req/ack handshake to the accelerator, and waits for done with a timeout. It then presents a one-cycle writeback result and releases the pipeline.

---
 rtl/acc_pkg.sv | 24 ++
 rtl/acc_timeout_cnt.sv | 50 +++++
 rtl/acc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_acc_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator-op sequencer.
// Contents:
//   OP_ACC0 / OP_ACC1 - the two accelerator opcodes recognised in decode
//   ST_*              - 3-bit sequencer state encoding
//   TIMEOUT_DEF       - default maximum BUSY cycles before abort
//   is_acc_op()       - opcode match helper
package acc_pkg;

  localparam logic [5:0] OP_ACC0 = 6'b111110;
  localparam logic [5:0] OP_ACC1 = 6'b111111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_BUSY = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam int unsigned TIMEOUT_DEF = 200;

  function automatic logic is_acc_op(input logic [5:0] op);
    return (op == OP_ACC0) || (op == OP_ACC1);
  endfunction

endpackage

// File: rtl/acc_timeout_cnt.sv
// Saturating BUSY-phase cycle counter with terminal-count flag.
// Ports:
//   clk, reset - clock and asynchronous active-low reset
//   clr_i      - synchronous clear (wins over enable)
//   en_i       - count enable
//   tc_o       - high while the count equals TIMEOUT-1
module acc_timeout_cnt
  import acc_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority; holding at all-ones prevents wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/acc_sequencer.sv
// Decode-stage sequencer for accelerator ops (opcodes 111111 / 111110).
// Detects an accelerator op in D, stalls F/D, runs a req/ack handshake,
// waits for done (with timeout) and presents a one-cycle writeback.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   opD, srcaD, srcbD   - decode opcode and register-file operands
//   flushD              - decode flush, suppresses detection
//   acc_ack, acc_done   - accelerator handshake inputs
//   acc_result          - accelerator result, valid with acc_done
//   err_clr             - clears the sticky timeout flag
//   acc_req             - request to accelerator (REQ state)
//   acc_mode/acc_a/acc_b- latched opD[0] and operands
//   stallFD, accbypass  - pipeline control
//   wb_valid, wb_data   - one-cycle writeback strobe and value
//   timeout_err         - sticky timeout flag
module acc_sequencer
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opD,
  input  logic [DATA_W-1:0] srcaD,
  input  logic [DATA_W-1:0] srcbD,
  input  logic              flushD,
  input  logic              acc_ack,
  input  logic              acc_done,
  input  logic [DATA_W-1:0] acc_result,
  input  logic              err_clr,
  output logic              acc_req,
  output logic              acc_mode,
  output logic [DATA_W-1:0] acc_a,
  output logic [DATA_W-1:0] acc_b,
  output logic              stallFD,
  output logic              accbypass,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              timeout_err
);

  logic [2:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              terr_q, terr_d;

  logic acc_op_det_s;
  logic cnt_clr_s;
  logic cnt_en_s;
  logic tc_s;
  logic timeout_set_s;

  assign acc_op_det_s  = is_acc_op(opD) & ~flushD;
  // Done in the terminal BUSY cycle takes priority over the timeout.
  assign timeout_set_s = (state_q == ST_BUSY) & tc_s & ~acc_done;

  acc_timeout_cnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr_s),
    .en_i  (cnt_en_s),
    .tc_o  (tc_s)
  );

  // Sequencer next-state, operand latch and writeback capture.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    a_d       = a_q;
    b_d       = b_q;
    wb_data_d = wb_data_q;
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_op_det_s) begin
          mode_d  = opD[0];
          a_d     = srcaD;
          b_d     = srcbD;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (acc_ack && acc_done) begin
          wb_data_d = acc_result;
          state_d   = ST_WB;
        end else if (acc_ack) begin
          cnt_clr_s = 1'b1;
          state_d   = ST_BUSY;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_BUSY: begin
        cnt_en_s = 1'b1;
        if (acc_done) begin
          wb_data_d = acc_result;
          state_d   = ST_WB;
        end else if (tc_s) begin
          wb_data_d = '0;
          state_d   = ST_ERR;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky timeout flag: a new timeout beats a simultaneous clear.
  always_comb begin
    if (timeout_set_s) begin
      terr_d = 1'b1;
    end else if (err_clr) begin
      terr_d = 1'b0;
    end else begin
      terr_d = terr_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      wb_data_q <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      wb_data_q <= wb_data_d;
      terr_q    <= terr_d;
    end
  end

  assign acc_req     = (state_q == ST_REQ);
  assign accbypass   = (state_q == ST_REQ) | (state_q == ST_BUSY);
  assign wb_valid    = (state_q == ST_WB) | (state_q == ST_ERR);
  // In IDLE the stall must follow detection in the same cycle.
  assign stallFD     = ((state_q == ST_IDLE) & acc_op_det_s) | accbypass;
  assign acc_mode    = mode_q;
  assign acc_a       = a_q;
  assign acc_b       = b_q;
  assign wb_data     = wb_data_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_acc_sequencer.sv
module tb_acc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opD;
  logic [31:0] srcaD, srcbD;
  logic        flushD, acc_ack, acc_done, err_clr;
  logic [31:0] acc_result;
  logic        acc_req, acc_mode, stallFD, accbypass, wb_valid, timeout_err;
  logic [31:0] acc_a, acc_b, wb_data;

  typedef struct {
    logic [31:0] data;
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  acc_sequencer #(.DATA_W(32), .CNT_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opD(opD), .srcaD(srcaD), .srcbD(srcbD),
    .flushD(flushD), .acc_ack(acc_ack), .acc_done(acc_done),
    .acc_result(acc_result), .err_clr(err_clr), .acc_req(acc_req),
    .acc_mode(acc_mode), .acc_a(acc_a), .acc_b(acc_b), .stallFD(stallFD),
    .accbypass(accbypass), .wb_valid(wb_valid), .wb_data(wb_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // Monitor: every writeback strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb @cyc %0d: got wb_valid=1 wb_data=%h expected no writeback", cyc, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("wb_data", wb_data, mon_e.data);
        chk("wb_mode", 32'(acc_mode), 32'(mon_e.mode));
        chk("wb_acc_a", acc_a, mon_e.a);
        chk("wb_acc_b", acc_b, mon_e.b);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Run one accelerator op; ack/done/err_clr are pulsed at the given
  // cycle offsets (cycle 0 = op in D); wb_at is the hand-computed WB cycle.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int ack_at, input int done_at, input logic [31:0] res,
                        input logic [31:0] exp_data, input logic exp_mode,
                        input int wb_at, input int clr_at);
    exp_t e;
    e.data = exp_data; e.mode = exp_mode; e.a = a; e.b = b; e.cyc = cyc + wb_at;
    exp_q.push_back(e);
    for (int k = 0; k <= wb_at; k++) begin
      opD        = op;
      srcaD      = (k == 0) ? a : ~a;
      srcbD      = (k == 0) ? b : ~b;
      flushD     = 1'b0;
      acc_ack    = (k == ack_at);
      acc_done   = (k == done_at);
      acc_result = (k == done_at) ? res : 32'hDEAD_BEEF;
      err_clr    = (k == clr_at);
      @(negedge clk);
      chk("stallFD", 32'(stallFD), 32'(k < wb_at));
      chk("acc_req", 32'(acc_req), 32'((k >= 1) && (k <= ack_at)));
      chk("accbypass", 32'(accbypass), 32'((k >= 1) && (k < wb_at)));
      if (k >= 1) begin
        chk("acc_mode", 32'(acc_mode), 32'(exp_mode));
        chk("acc_a", acc_a, a);
      end
      nxt();
    end
    opD = 6'd0; acc_ack = 1'b0; acc_done = 1'b0; err_clr = 1'b0;
    srcaD = 32'd0; srcbD = 32'd0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got time limit expired expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; opD = 6'd0; srcaD = 32'd0; srcbD = 32'd0; flushD = 1'b0;
    acc_ack = 1'b0; acc_done = 1'b0; acc_result = 32'd0; err_clr = 1'b0;
    nxt(); nxt();
    @(negedge clk);
    chk("rst_acc_req", 32'(acc_req), 32'd0);
    chk("rst_stallFD", 32'(stallFD), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_acc_a", acc_a, 32'd0);
    nxt();
    reset = 1'b1;
    nxt();

    // Ack at 1, done at 4 -> WB at 5.
    run_op(6'b111111, 32'h5, 32'h7, 1, 4, 32'hC, 32'hC, 1'b1, 5, -1);
    // Ack and done together at 1 -> WB at 2.
    run_op(6'b111110, 32'h1234, 32'h5678, 1, 1, 32'hFFFF0000, 32'hFFFF0000, 1'b0, 2, -1);
    // Late ack at 3, done at 5 -> WB at 6.
    run_op(6'b111111, 32'hAAAA, 32'hBBBB, 3, 5, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1, 6, -1);

    // Flushed op is ignored; stray ack/done in IDLE do nothing.
    opD = 6'b111111; srcaD = 32'h99; flushD = 1'b1;
    @(negedge clk);
    chk("flush_stallFD", 32'(stallFD), 32'd0);
    nxt();
    opD = 6'd0; flushD = 1'b0; acc_done = 1'b1; acc_ack = 1'b1; acc_result = 32'h1111;
    @(negedge clk);
    chk("flush_acc_req", 32'(acc_req), 32'd0);
    chk("flush_stallFD2", 32'(stallFD), 32'd0);
    nxt();
    acc_done = 1'b0; acc_ack = 1'b0;
    @(negedge clk);
    chk("stray_wb_valid", 32'(wb_valid), 32'd0);
    chk("stray_acc_req", 32'(acc_req), 32'd0);
    nxt();

    // Back-to-back: second op enters D the cycle after the first WB.
    run_op(6'b111111, 32'h5, 32'h7, 1, 2, 32'h22, 32'h22, 1'b1, 3, -1);
    run_op(6'b111110, 32'h11, 32'h33, 1, 1, 32'h44, 32'h44, 1'b0, 2, -1);

    // Timeout (4 BUSY cycles) with err_clr colliding in the terminal cycle.
    run_op(6'b111111, 32'hCAFE, 32'hBEEF, 1, -1, 32'h0, 32'h0, 1'b1, 6, 5);
    @(negedge clk);
    chk("terr_set_wins", 32'(timeout_err), 32'd1);
    nxt();
    @(negedge clk);
    chk("terr_sticky", 32'(timeout_err), 32'd1);
    nxt();

    // Reset in the middle of BUSY.
    opD = 6'b111111; srcaD = 32'hA5A5A5A5; srcbD = 32'h5A5A5A5A;
    nxt();
    acc_ack = 1'b1;
    nxt();
    acc_ack = 1'b0;
    @(negedge clk);
    chk("busy_acc_req", 32'(acc_req), 32'd0);
    chk("busy_stallFD", 32'(stallFD), 32'd1);
    chk("busy_terr_sticky", 32'(timeout_err), 32'd1);
    nxt();
    reset = 1'b0; opD = 6'd0;
    @(negedge clk);
    chk("midrst_acc_req", 32'(acc_req), 32'd0);
    chk("midrst_stallFD", 32'(stallFD), 32'd0);
    chk("midrst_accbypass", 32'(accbypass), 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
    chk("midrst_acc_a", acc_a, 32'd0);
    nxt();
    reset = 1'b1;
    @(negedge clk);
    chk("postrst_acc_req", 32'(acc_req), 32'd0);
    nxt();

    // Second timeout, then err_clr pulse clears the flag.
    run_op(6'b111110, 32'h77, 32'h88, 1, -1, 32'h0, 32'h0, 1'b0, 6, -1);
    @(negedge clk);
    chk("terr_set", 32'(timeout_err), 32'd1);
    nxt();
    err_clr = 1'b1;
    @(negedge clk);
    chk("terr_held_during_clr", 32'(timeout_err), 32'd1);
    nxt();
    err_clr = 1'b0;
    @(negedge clk);
    chk("terr_cleared", 32'(timeout_err), 32'd0);
    nxt();

    // Normal op still works after a timeout.
    run_op(6'b111111, 32'h3, 32'h4, 1, 3, 32'h7, 32'h7, 1'b1, 4, -1);
    nxt();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
